// File: rtl/tulip_audio_pkg.sv
// Shared audio-path definitions for the tulip DSP output stage.
// Holds the sample type, the I2S slot encoding, and the frame geometry defaults.
package tulip_audio_pkg;

  localparam int C_ADC_DWIDTH = 24;

  typedef logic signed [C_ADC_DWIDTH-1:0] sample_t;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  localparam int C_SLOT_WIDTH = 32;
  localparam int C_BCLK_DIV   = 4;

endpackage

// File: rtl/tulip_i2s_clkgen.sv
// I2S bus-master timing: divides clk into BCLK and tracks the bit position within a frame.
// Strobes are combinational on the current state and coincide with the clk edge that applies them.
module tulip_i2s_clkgen
  import tulip_audio_pkg::*;
#(
  parameter int G_SLOT_WIDTH = C_SLOT_WIDTH,
  parameter int G_BCLK_DIV   = C_BCLK_DIV,
  parameter int CW           = $clog2(2 * G_SLOT_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          bclk_o,
  output logic          fall_o,
  output logic          frame_start_o,
  output logic [CW-1:0] bit_cnt_d_o
);

  localparam int DIVW = (G_BCLK_DIV > 1) ? $clog2(G_BCLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_TC = DIVW'(G_BCLK_DIV - 1);
  localparam logic [CW-1:0]   BIT_TC = CW'(2 * G_SLOT_WIDTH - 1);

  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            bclk_q, bclk_d;
  logic            tc, fall;

  always_comb begin
    tc        = (div_cnt_q == DIV_TC);
    fall      = tc & bclk_q;
    div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
    bclk_d    = tc ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    if (fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_TC) ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else if (!enable) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o        = bclk_q;
  assign fall_o        = fall;
  assign frame_start_o = fall & (bit_cnt_q == BIT_TC);
  assign bit_cnt_d_o   = bit_cnt_d;

endmodule

// File: rtl/tulip_i2s_tx.sv
// Mono-to-stereo I2S transmitter: one holding register paces the DSP chain at one sample per frame,
// the same word is sent in both slots, and an empty holding register at frame start repeats the last word.
module tulip_i2s_tx
  import tulip_audio_pkg::*;
#(
  parameter int G_DWIDTH     = C_ADC_DWIDTH,
  parameter int G_SLOT_WIDTH = C_SLOT_WIDTH,
  parameter int G_BCLK_DIV   = C_BCLK_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [G_DWIDTH-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                frame_tick,
  output logic                underrun,
  output logic [15:0]         underrun_count
);

  localparam int CW = $clog2(2 * G_SLOT_WIDTH);
  localparam logic [CW-1:0] SLOT_C = CW'(G_SLOT_WIDTH);

  logic          bclk, bclk_fall, frame_start;
  logic [CW-1:0] bit_cnt_d, pos;

  tulip_i2s_clkgen #(
    .G_SLOT_WIDTH(G_SLOT_WIDTH),
    .G_BCLK_DIV  (G_BCLK_DIV),
    .CW          (CW)
  ) u_clkgen (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bclk_o       (bclk),
    .fall_o       (bclk_fall),
    .frame_start_o(frame_start),
    .bit_cnt_d_o  (bit_cnt_d)
  );

  logic [G_DWIDTH-1:0] hold_q, hold_d, shift_q, shift_d, last_q, last_d;
  logic                full_q, full_d, ready_q, accept;
  logic                urun_q, urun_d, sdata_q, sdata_d, tick_q;
  logic [15:0]         cnt_q, cnt_d;
  slot_e               lrclk_q, lrclk_d;

  // din handshake: a transfer happens on a clk edge where din_valid and din_ready are both 1.
  // din_ready is a register equal to "holding empty", so it never depends on din_valid.
  always_comb begin
    accept = din_valid & ready_q;
    hold_d = hold_q;
    full_d = full_q;
    shift_d = shift_q;
    last_d = last_q;
    urun_d = urun_q;
    cnt_d = cnt_q;
    if (frame_start) begin
      if (full_q) begin
        shift_d = hold_q;
        last_d  = hold_q;
        full_d  = 1'b0;
      end else begin
        shift_d = last_q;
        urun_d  = 1'b1;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
    end
    if (accept) begin
      hold_d = din;
      full_d = 1'b1;
    end
  end

  // Position 0 of each slot is the I2S one-BCLK delay; bits past the word are padding.
  always_comb begin
    pos     = (bit_cnt_d >= SLOT_C) ? bit_cnt_d - SLOT_C : bit_cnt_d;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    if (bclk_fall) begin
      lrclk_d = (bit_cnt_d >= SLOT_C) ? SLOT_RIGHT : SLOT_LEFT;
      sdata_d = 1'b0;
      for (int i = 0; i < G_DWIDTH; i++) begin
        if (pos == CW'(G_DWIDTH - i)) sdata_d = shift_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q  <= '0;
      shift_q <= '0;
      last_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      urun_q  <= 1'b0;
      cnt_q   <= '0;
      sdata_q <= 1'b0;
      lrclk_q <= SLOT_LEFT;
      tick_q  <= 1'b0;
    end else if (!enable) begin
      hold_q  <= '0;
      shift_q <= '0;
      last_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      urun_q  <= 1'b0;
      cnt_q   <= '0;
      sdata_q <= 1'b0;
      lrclk_q <= SLOT_LEFT;
      tick_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      full_q  <= full_d;
      ready_q <= ~full_d;
      urun_q  <= urun_d;
      cnt_q   <= cnt_d;
      sdata_q <= sdata_d;
      lrclk_q <= lrclk_d;
      tick_q  <= frame_start;
    end
  end

  assign din_ready      = ready_q;
  assign i2s_bclk       = bclk;
  assign i2s_lrclk      = lrclk_q;
  assign i2s_sdata      = sdata_q;
  assign frame_tick     = tick_q;
  assign underrun       = urun_q;
  assign underrun_count = cnt_q;

endmodule

// File: tb/tb_tulip_i2s_tx.sv
// Bench for tulip_i2s_tx with G_BCLK_DIV=1: 2-clk BCLK, 128-clk frame, slot-level decode against a sample queue.
module tb_tulip_i2s_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [23:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        frame_tick;
  logic        underrun;
  logic [15:0] underrun_count;

  tulip_i2s_tx #(
    .G_DWIDTH    (24),
    .G_SLOT_WIDTH(32),
    .G_BCLK_DIV  (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdata     (i2s_sdata),
    .frame_tick    (frame_tick),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  int          urun_cnt = 0;
  logic [23:0] exp_q[$];
  logic [23:0] src_q[$];
  logic [23:0] cur_w, last_w, rx;
  bit          pad_bad;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, n);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_bclk"},  32'(i2s_bclk), 32'd0);
    check_eq({tag, "_lrclk"}, 32'(i2s_lrclk), 32'd0);
    check_eq({tag, "_sdata"}, 32'(i2s_sdata), 32'd0);
    check_eq({tag, "_tick"},  32'(frame_tick), 32'd0);
    check_eq({tag, "_ready"}, 32'(din_ready), 32'd0);
    check_eq({tag, "_urun"},  32'(underrun), 32'd0);
    check_eq({tag, "_cnt"},   32'(underrun_count), 32'd0);
  endtask

  task automatic model_reset();
    n = 0;
    urun_cnt = 0;
    exp_q.delete();
    cur_w = '0;
    last_w = '0;
    rx = '0;
    pad_bad = 1'b0;
  endtask

  // driver
  task automatic drive();
    if (src_q.size() > 0) begin
      din_valid = 1'b1;
      din = src_q[0];
    end else begin
      din_valid = 1'b0;
      din = 24'($urandom_range(0, 32'h00FF_FFFF));
    end
  endtask

  // one clk: apply the model for the coming edge, check everything after it, then drive
  task automatic step();
    logic        acc, en_edge;
    logic [23:0] din_edge;
    int          b, pos;
    acc = din_valid & din_ready & enable;
    en_edge = enable;
    din_edge = din;
    @(posedge clk);
    #1;
    if (!en_edge) begin
      model_reset();
      check_idle("en_clr");
    end else begin
      n++;
      if (n % 128 == 0) begin
        if (exp_q.size() > 0) begin
          cur_w = exp_q.pop_front();
          last_w = cur_w;
        end else begin
          cur_w = last_w;
          urun_cnt++;
        end
      end
      if (acc) begin
        exp_q.push_back(din_edge);
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      b = (n / 2) % 64;
      check_eq("bclk",  32'(i2s_bclk), 32'(n % 2));
      check_eq("tick",  32'(frame_tick), (n % 128 == 0) ? 32'd1 : 32'd0);
      check_eq("lrclk", 32'(i2s_lrclk), (b >= 32) ? 32'd1 : 32'd0);
      check_eq("ready", 32'(din_ready), (exp_q.size() == 0) ? 32'd1 : 32'd0);
      check_eq("urun",  32'(underrun), (urun_cnt > 0) ? 32'd1 : 32'd0);
      check_eq("ucnt",  32'(underrun_count), 32'(urun_cnt));
      if (n % 2 == 0) begin
        pos = b % 32;
        if (pos >= 1 && pos <= 24) rx[24 - pos] = i2s_sdata;
        else if (i2s_sdata !== 1'b0) pad_bad = 1'b1;
        if (pos == 31) begin
          check_eq((b >= 32) ? "word_r" : "word_l", 32'(rx), 32'(cur_w));
          check_eq("pad", 32'(pad_bad), 32'd0);
          rx = '0;
          pad_bad = 1'b0;
        end
      end
    end
    drive();
  endtask

  // stimulus
  initial begin
    reset = 1'b0;
    enable = 1'b1;
    din_valid = 1'b0;
    din = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle("rst");
    reset = 1'b1;

    // back-to-back stream, then supply stops so the last word repeats with underruns
    src_q = '{24'h800001, 24'h123456, 24'hABCDEF, 24'h7FFFFF};
    drive();
    while (n < 895) step();

    // sample presented so that it is accepted on the same edge as a frame start
    src_q.push_back(24'h5A5A5A);
    drive();
    while (n < 1252) step();

    // asynchronous reset in the middle of the right slot
    #1 reset = 1'b0;
    #1 check_idle("rst_mid");
    model_reset();
    repeat (2) @(negedge clk);
    check_idle("rst_hold");
    reset = 1'b1;
    src_q.push_back(24'h0F0F0F);
    drive();
    while (n < 300) step();

    // synchronous soft clear via enable
    enable = 1'b0;
    step();
    enable = 1'b1;
    while (n < 140) step();

    check_eq("src_drained", 32'(src_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
